// File: rtl/axi4stream_rr_arbiter.sv
// rtl/axi4stream_rr_arbiter.sv - packet-level round-robin arbiter for N AXI4-Stream sources onto one sink
module axi4stream_rr_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 256,
  parameter int ID_WIDTH   = $clog2(N_PORTS)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  output logic [N_PORTS-1:0]            s_axis_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          busy,
  output logic [N_PORTS-1:0]            err_trunc,
  input  logic                          err_clr
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [N_PORTS-1:0]   err_q, err_d;

  logic [ID_WIDTH-1:0]  winner;
  logic                 found;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                 active;
  logic                 forced;
  logic                 hs;

  // grant_q doubles as last_grant: it is only rewritten with the winner at IDLE->BUSY
  assign active = (state_q == BUSY) && !areset;
  assign forced = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign hs     = m_axis_tvalid && m_axis_tready;

  // Round-robin search starting one past the previous grant, wrapping around
  always_comb begin
    winner = grant_q;
    found  = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (!found && (p == (int'(grant_q) + i) % N_PORTS) && s_axis_tvalid[p]) begin
          found  = 1'b1;
          winner = ID_WIDTH'(p);
        end
      end
    end
  end

  // Select the granted source's valid/data/last and steer tready back to it only
  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    s_axis_tready = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_q == ID_WIDTH'(p)) begin
        sel_valid        = s_axis_tvalid[p];
        sel_last         = s_axis_tlast[p];
        sel_data         = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        s_axis_tready[p] = active && m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = active && sel_valid;
  assign m_axis_tdata  = sel_data;
  assign m_axis_tlast  = sel_last || forced;
  assign m_axis_tid    = grant_q;
  assign busy          = (state_q == BUSY);
  assign err_trunc     = err_q;

  // Next-state: arbitrate in IDLE, count beats and close the packet in BUSY
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_clr ? '0 : err_q;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          state_d    = BUSY;
          grant_d    = winner;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (forced && !sel_last) begin
            for (int p = 0; p < N_PORTS; p++) begin
              if (grant_q == ID_WIDTH'(p)) begin
                err_d[p] = 1'b1;
              end
            end
          end
          if (m_axis_tlast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset gives port 0 top priority on the first arbitration
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= ID_WIDTH'(N_PORTS - 1);
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4stream_rr_arbiter.sv
// tb/tb_axi4stream_rr_arbiter.sv - directed and randomized checks of the round-robin stream arbiter
module tb_axi4stream_rr_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic        busy;
  logic [3:0]  err;
  logic        err_clr;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [1:0] tid;
    logic [7:0] d;
    logic       l;
  } exp_t;

  beat_t src_q[4][$];
  beat_t mq[4][$];
  exp_t  exp_q[$];

  axi4stream_rr_arbiter #(
    .N_PORTS(4),
    .DATA_WIDTH(8),
    .MAX_BEATS(4)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid),
    .busy(busy),
    .err_trunc(err),
    .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[p]       = v;
    s_tdata[p*8 +: 8] = d;
    s_tlast[p]        = l;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_sready"}, 32'(s_tready), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int tid, input logic [7:0] d, input logic l);
    logic [3:0] rdy;
    rdy = m_tready ? 4'(1 << tid) : 4'b0000;
    #1;
    chk({tag, "_busy"},   32'(busy),     32'd1);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_tid"},    32'(m_tid),    32'(tid));
    chk({tag, "_data"},   32'(m_tdata),  32'(d));
    chk({tag, "_last"},   32'(m_tlast),  32'(l));
    chk({tag, "_sready"}, 32'(s_tready), 32'(rdy));
  endtask

  task automatic do_reset(input string tag);
    areset   = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    err_clr  = 1'b0;
    #1;
    chk({tag, "_rst_mvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_rst_sready"}, 32'(s_tready), 32'd0);
    cyc();
    chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rst_err"},  32'(err),  32'd0);
    areset = 1'b0;
  endtask

  initial begin
    int last, npkt, idx, bubbles, cycles, p, n, npk, len;
    logic [3:0] exp_err;
    logic found, done, fl;
    beat_t bt;

    areset   = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    err_clr  = 1'b0;

    // 1: three-beat packet from port 0
    do_reset("t1");
    set_port(0, 1'b1, 8'h11, 1'b0);
    chk_idle("t1_decide"); cyc();
    chk_beat("t1_b1", 0, 8'h11, 1'b0); cyc();
    set_port(0, 1'b1, 8'h22, 1'b0);
    chk_beat("t1_b2", 0, 8'h22, 1'b0); cyc();
    set_port(0, 1'b1, 8'h33, 1'b1);
    chk_beat("t1_b3", 0, 8'h33, 1'b1); cyc();
    set_port(0, 1'b0, 8'h00, 1'b0);
    chk_idle("t1_end");

    // 2: all ports valid with 1-beat packets, one bubble per packet
    do_reset("t2");
    for (int q = 0; q < 4; q++) set_port(q, 1'b1, 8'(8'hA0 + q), 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk_idle($sformatf("t2_idle%0d", k)); cyc();
      chk_beat($sformatf("t2_beat%0d", k), k % 4, 8'(8'hA0 + k % 4), 1'b1); cyc();
    end
    s_tvalid = '0;

    // 6: last grant is 1, ports 1 and 2 request together -> port 2 first
    set_port(1, 1'b1, 8'hB1, 1'b1);
    set_port(2, 1'b1, 8'hB2, 1'b1);
    chk_idle("t6_idle0"); cyc();
    chk_beat("t6_p2", 2, 8'hB2, 1'b1); cyc();
    set_port(2, 1'b0, 8'h00, 1'b0);
    chk_idle("t6_idle1"); cyc();
    chk_beat("t6_p1", 1, 8'hB1, 1'b1); cyc();
    set_port(1, 1'b0, 8'h00, 1'b0);

    // 3: backpressure mid-packet, competing port must wait for tlast
    do_reset("t3");
    set_port(1, 1'b1, 8'h51, 1'b0);
    set_port(2, 1'b1, 8'hC2, 1'b1);
    chk_idle("t3_decide"); cyc();
    chk_beat("t3_b1", 1, 8'h51, 1'b0); cyc();
    set_port(1, 1'b1, 8'h52, 1'b1);
    m_tready = 1'b0;
    chk_beat("t3_stall", 1, 8'h52, 1'b1); cyc();
    m_tready = 1'b1;
    chk_beat("t3_b2", 1, 8'h52, 1'b1); cyc();
    set_port(1, 1'b0, 8'h00, 1'b0);
    chk_idle("t3_gap"); cyc();
    chk_beat("t3_p2", 2, 8'hC2, 1'b1); cyc();
    set_port(2, 1'b0, 8'h00, 1'b0);

    // 4: truncation at MAX_BEATS=4, set wins over a simultaneous clear
    set_port(3, 1'b1, 8'h61, 1'b0);
    chk_idle("t4_decide"); cyc();
    for (int b = 1; b <= 3; b++) begin
      set_port(3, 1'b1, 8'(8'h60 + b), 1'b0);
      chk_beat($sformatf("t4_b%0d", b), 3, 8'(8'h60 + b), 1'b0); cyc();
    end
    set_port(3, 1'b1, 8'h64, 1'b0);
    err_clr = 1'b1;
    chk_beat("t4_b4", 3, 8'h64, 1'b1); cyc();
    err_clr = 1'b0;
    chk_idle("t4_rearb");
    chk("t4_err_set", 32'(err), 32'h8);
    cyc();
    set_port(3, 1'b1, 8'h65, 1'b0);
    chk_beat("t4_b5", 3, 8'h65, 1'b0); cyc();
    set_port(3, 1'b1, 8'h66, 1'b0);
    chk_beat("t4_b6", 3, 8'h66, 1'b0); cyc();
    set_port(3, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t4_hold_busy",   32'(busy),     32'd1);
    chk("t4_hold_mvalid", 32'(m_tvalid), 32'd0);
    chk("t4_err_kept",    32'(err),      32'h8);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("t4_err_clr", 32'(err), 32'h0);

    // 5: reset during beat 2 abandons the packet
    do_reset("t5");
    set_port(0, 1'b1, 8'h71, 1'b0);
    chk_idle("t5_decide"); cyc();
    chk_beat("t5_b1", 0, 8'h71, 1'b0); cyc();
    set_port(0, 1'b1, 8'h72, 1'b0);
    areset = 1'b1;
    #1;
    chk("t5_rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("t5_rst_sready", 32'(s_tready), 32'd0);
    cyc();
    areset = 1'b0;
    set_port(1, 1'b1, 8'h81, 1'b1);
    chk_idle("t5_after"); cyc();
    chk_beat("t5_regrant", 0, 8'h72, 1'b0);

    // Randomized packets against a packet-level round-robin model
    do_reset("rnd");
    for (int q = 0; q < 4; q++) begin
      src_q[q].delete();
      npk = $urandom_range(1, 4);
      for (int k = 0; k < npk; k++) begin
        len = $urandom_range(1, 7);
        for (int b = 0; b < len; b++) begin
          bt.d = 8'($urandom);
          bt.l = (b == len - 1);
          src_q[q].push_back(bt);
        end
      end
      mq[q] = src_q[q];
    end
    exp_q.delete();
    exp_err = '0;
    last = 3;
    npkt = 0;
    while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
      found = 1'b0;
      p = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && mq[(last + i) % 4].size() > 0) begin
          found = 1'b1;
          p = (last + i) % 4;
        end
      end
      n = 0;
      done = 1'b0;
      while (!done) begin
        bt = mq[p].pop_front();
        n++;
        fl = bt.l || (n == 4);
        if (n == 4 && !bt.l) exp_err[p] = 1'b1;
        exp_q.push_back({2'(p), bt.d, fl});
        done = fl;
      end
      last = p;
      npkt++;
    end

    idx = 0;
    bubbles = 0;
    cycles = 0;
    while (idx < exp_q.size() && cycles < 2000) begin
      for (int q = 0; q < 4; q++) begin
        if (src_q[q].size() > 0) begin
          set_port(q, 1'b1, src_q[q][0].d, src_q[q][0].l);
        end else begin
          set_port(q, 1'b0, 8'h00, 1'b0);
        end
      end
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_tvalid && m_tready) begin
        chk($sformatf("rnd_tid%0d", idx),  32'(m_tid),   32'(exp_q[idx].tid));
        chk($sformatf("rnd_data%0d", idx), 32'(m_tdata), 32'(exp_q[idx].d));
        chk($sformatf("rnd_last%0d", idx), 32'(m_tlast), 32'(exp_q[idx].l));
        idx++;
      end else if (!m_tvalid) begin
        bubbles++;
      end
      for (int q = 0; q < 4; q++) begin
        if (s_tvalid[q] && s_tready[q] && src_q[q].size() > 0) void'(src_q[q].pop_front());
      end
      cyc();
      cycles++;
    end
    s_tvalid = '0;
    chk("rnd_beats_done", 32'(idx),     32'(exp_q.size()));
    chk("rnd_bubbles",    32'(bubbles), 32'(npkt));
    #1;
    chk("rnd_err",        32'(err),     32'(exp_err));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("rnd_err_clr", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
